// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// FSM state encoding plus a helper that sizes the bit counter.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SERIAL_ADDER_DEFAULT_WIDTH = 8;

  // Counter must still be one bit wide when WIDTH is 1.
  function automatic int cnt_width(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/fa_cell.sv
// Combinational one-bit full adder cell used by the serial datapath.
// No state; sum and carry follow the inputs directly.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one operand bit per clock, LSB first, result after WIDTH RUN cycles.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN (adds port sub).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADDER_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic fa_x, fa_y, fa_s, fa_co;

  assign fa_x = a_q[cnt_q];
  assign fa_y = b_q[cnt_q];

  fa_cell u_fa (
    .x  (fa_x),
    .y  (fa_y),
    .ci (c_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
`ifdef SERIAL_ADDER_SUB_EN
          // Subtraction is a + ~b + 1; the stored b is pre-inverted so RUN is unchanged.
          b_d     = sub ? ~b : b;
          c_d     = sub ? 1'b1 : cin;
`else
          b_d     = b;
          c_d     = cin;
`endif
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
        end
      end
      RUN: begin
        sum_d[cnt_q] = fa_s;
        c_d          = fa_co;
        if (cnt_q == LAST) begin
          state_d = DONE;
          cout_d  = fa_co;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder at WIDTH=8: arithmetic/latency reference model plus directed and random operations.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub_drv = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_done = -100;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub_drv),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: result is plain arithmetic; timing is "WIDTH cycles busy, then one done cycle".
  int           m_phase = 0;
  int           m_left = 0;
  logic [W:0]   m_pend = '0;
  logic [W-1:0] m_sum = '0;
  logic         m_cout = 1'b0;
  bit           m_known = 0;
  bit           m_armed = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase = 0; m_sum = '0; m_cout = 1'b0; m_known = 1; m_armed = 1;
    end else begin
      case (m_phase)
        0: if (start) begin
          if (sub_drv) m_pend = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
          else         m_pend = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
          m_phase = 1; m_left = W; m_known = 0;
        end
        1: begin
          m_left--;
          if (m_left == 0) begin
            m_phase = 2; {m_cout, m_sum} = m_pend; m_known = 1;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_armed) begin
      chk("busy", busy, m_phase == 1);
      chk("done", done, m_phase == 2);
      if (m_known) begin
        chk("sum", sum, m_sum);
        chk("cout", cout, m_cout);
      end
    end
  end

  // Called at a negedge; holds start until accepted, then waits for done.
  task automatic op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                    input logic isub, input bit lit, input logic [W-1:0] esum,
                    input logic ecout, input bit btb, output int acc);
    bit ok;
    a = ia; b = ib; cin = ic; sub_drv = isub; start = 1'b1;
    ok = 0; acc = -1;
    for (int t = 0; t < W + 4; t++) begin
      @(posedge clk); @(negedge clk);
      if (busy) begin ok = 1; break; end
    end
    chk("accept_seen", ok, 1);
    acc = cyc;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub_drv = ~isub;
    ok = 0;
    for (int t = 0; t < W + 4; t++) begin
      if (done) begin ok = 1; break; end
      @(negedge clk);
    end
    chk("done_seen", ok, 1);
    if (ok) begin
      chk("latency", 64'(cyc - acc), W);
      if (lit) begin
        chk("lit_sum", sum, esum);
        chk("lit_cout", cout, ecout);
      end
      if (btb) chk("throughput", 64'(cyc - last_done), W + 2);
      last_done = cyc;
    end
    sub_drv = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 1 ms");
    $fatal(1);
  end

  initial begin
    int acc, rst_cyc;
    bit first;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    rst_n = 1'b1;
    @(negedge clk);

    op(8'h00, 8'h00, 1'b0, 1'b0, 1, 8'h00, 1'b0, 0, acc);
    op(8'hFF, 8'h01, 1'b0, 1'b0, 1, 8'h00, 1'b1, 1, acc);
    op(8'hA5, 8'h5A, 1'b1, 1'b0, 1, 8'h00, 1'b1, 1, acc);
    op(8'h80, 8'h80, 1'b1, 1'b0, 1, 8'h01, 1'b1, 1, acc);
    op(8'h3C, 8'h0F, 1'b0, 1'b0, 1, 8'h4B, 1'b0, 1, acc);
`ifdef SERIAL_ADDER_SUB_EN
    op(8'h10, 8'h01, 1'b0, 1'b1, 1, 8'h0F, 1'b1, 1, acc);
    op(8'h01, 8'h02, 1'b1, 1'b1, 1, 8'hFF, 1'b0, 1, acc);
`endif

    // start held high with changing operands: only the accepting cycles' operands count.
    repeat (2) @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    for (int t = 0; t < W + 4 && !busy; t++) @(negedge clk);
    first = 1;
    for (int t = 0; t < 3 * (W + 2); t++) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      @(negedge clk);
      if (done && first) begin
        chk("hold_sum", sum, 8'h46);
        chk("hold_cout", cout, 0);
        first = 0;
      end
    end
    start = 1'b0;
    repeat (W + 3) @(negedge clk);

    // Reset on the 4th RUN edge aborts the operation.
    a = 8'h37; b = 8'h11; cin = 1'b0; start = 1'b1;
    for (int t = 0; t < W + 4 && !busy; t++) @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_sum", sum, 0);
    chk("abort_cout", cout, 0);
    rst_n = 1'b1;
    rst_cyc = cyc;
    op(8'h21, 8'h43, 1'b1, 1'b0, 1, 8'h65, 1'b0, 0, acc);
    chk("accept_after_rst", 64'(acc - rst_cyc), 1);

    // Random sweep, mixing back-to-back and idle-gapped operations.
    for (int i = 0; i < 1000; i++) begin
      bit gap;
      logic s;
      gap = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      s = 1'($urandom);
`else
      s = 1'b0;
`endif
      if (gap) repeat ($urandom_range(1, 3)) @(negedge clk);
      op(W'($urandom), W'($urandom), 1'($urandom), s, 0, '0, 1'b0, !gap, acc);
    end
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
- REQ-001 SHALL have parameter WIDTH, default 8: operand/result width in bits; legal range 1..64.
- REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
- REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
- REQ-004 SHALL have port start  input  1  request to begin one addition; sampled only in IDLE.
- REQ-005 SHALL have port a  input  WIDTH  augend; sampled on the accepting edge only.
- REQ-006 SHALL have port b  input  WIDTH  addend; sampled on the accepting edge only.
- REQ-007 SHALL have port cin  input  1  carry-in; sampled on the accepting edge only.
- REQ-008 SHALL have port busy  output  1  high while the FSM is in RUN.
- REQ-009 SHALL have port done  output  1  one-cycle pulse; sum and cout are valid from this cycle.
- REQ-010 SHALL have port sum  output  WIDTH  registered result.
- REQ-011 SHALL have port cout  output  1  registered carry-out of the MSB.

Function
- REQ-012 SHALL implement FSM states IDLE, RUN and DONE.
- REQ-013 Transition IDLE->RUN SHALL occur on an edge with start=1; that edge latches a, b, cin, clears the bit counter and clears sum.
- REQ-014 RUN SHALL process one bit per edge, LSB first: sum[i] <= a_r[i]^b_r[i]^c and c <= majority(a_r[i], b_r[i], c).
- REQ-015 After exactly WIDTH RUN edges, the FSM SHALL enter DONE and cout SHALL equal the final carry.
- REQ-016 DONE SHALL last one cycle (done=1, busy=0) and then return unconditionally to IDLE.
- REQ-017 Latency: with start accepted at edge k, done SHALL be high between edges k+WIDTH and k+WIDTH+1.
- REQ-018 start SHALL be ignored in RUN and DONE; no queuing; operand changes after acceptance SHALL have no effect.
- REQ-019 sum and cout SHALL hold their values from DONE until the next accepting edge.
- REQ-020 The bit counter width SHALL be max(1, $clog2(WIDTH)); WIDTH=1 SHALL complete in one RUN cycle.
- REQ-021 Back-to-back operation: start=1 in the IDLE cycle directly after DONE SHALL be accepted, giving a throughput of one result per WIDTH+2 cycles.

Reset
- REQ-022 When rst_n=0 at a rising edge, the block SHALL set state=IDLE, busy=0, done=0, sum=0, cout=0, counter=0 and carry=0.
- REQ-023 Reset asserted mid-RUN SHALL abort the operation with no done pulse; start in the first cycle after release SHALL be accepted normally.
- REQ-024 Reset SHALL take priority over start.

Configuration
- REQ-025 With SERIAL_ADDER_SUB_EN defined, the block SHALL add port sub (input, 1), sampled with the operands; sub=1 SHALL compute a-b by inverting b_r and forcing the initial carry to 1 (cin ignored), and cout=1 SHALL mean no borrow.
- REQ-026 Without SERIAL_ADDER_SUB_EN, the sub port SHALL be absent and the block SHALL only add.

Structure
- REQ-027 Package serial_adder_pkg SHALL hold the FSM state typedef (IDLE, RUN, DONE) and the constant SERIAL_ADDER_DEFAULT_WIDTH=8.
- REQ-028 The combinational one-bit sum/carry cell SHALL be a sub-module fa_cell (inputs x, y, ci; outputs s, co) instantiated once inside the RUN datapath.

Verification (WIDTH=8)
- REQ-029 a=0x00, b=0x00, cin=0, start pulsed at edge 0 -> busy high for edges 0..7, done at edge 8, sum=0x00, cout=0.
- REQ-030 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1.
- REQ-031 start held high continuously with different operands while busy -> only the first operands are used; the next acceptance occurs at the IDLE cycle after done.
- REQ-032 rst_n=0 at the 4th RUN edge -> next cycle busy=0, sum=0, cout=0, and no done pulse occurs.
- REQ-033 With SERIAL_ADDER_SUB_EN: a=0x10, b=0x01, sub=1 -> sum=0x0F, cout=1; a=0x01, b=0x02, sub=1 -> sum=0xFF, cout=0.
- REQ-034 Random sweep of 1000 operand sets against the reference model {cout,sum}=a+b+cin -> zero mismatches; done pulse width is always exactly 1 cycle.
